// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   scan_state_e : scan FSM states (IDLE, BLANK, ON)
//   SEG_BLANK    : segment pattern that lights nothing
//   MAX_DIGITS   : largest digit count the controller supports
//   enb_off()    : inactive digit-enable vector for a given polarity and
//                  digit count (bits above n are always 0)
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK  = 7'b0;
    localparam int         MAX_DIGITS = 16;

    function automatic logic [MAX_DIGITS-1:0] enb_off(input logic active_low, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (active_low && (i < n)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/seg_scan_timebase.sv
// ---------------------------------------------------------------------------
// seg_scan_timebase
// Timing counters for the scan controller: the per-slot dwell counter, the
// free-running 4-bit PWM counter and the blink counter/phase.
//   clk, rst_n    : clock, asynchronous active-low reset
//   run_i         : advance the dwell and blink counters
//   restart_i     : clear dwell/blink counters, force blink phase on
//                   (takes priority over run_i)
//   slot_end_o    : dwell counter is on the last cycle of the slot
//   blank_done_o  : dwell counter is on the last guard cycle
//   pwm_cnt_o     : PWM count that applies to the upcoming cycle
//   blink_on_o    : blink phase that applies to the upcoming cycle
// ---------------------------------------------------------------------------
module seg_scan_timebase #(
    parameter int DWELL      = 50000,
    parameter int BLANK_CYC  = 64,
    parameter int BLINK_HALF = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       restart_i,
    output logic       slot_end_o,
    output logic       blank_done_o,
    output logic [3:0] pwm_cnt_o,
    output logic       blink_on_o
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] BLANK_LAST = DW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_comb begin
        pwm_d       = pwm_q + 4'd1;
        dwell_d     = dwell_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (restart_i) begin
            dwell_d     = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (run_i) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q     <= '0;
            pwm_q       <= 4'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            dwell_q     <= dwell_d;
            pwm_q       <= pwm_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign slot_end_o   = (dwell_q == DWELL_LAST);
    assign blank_done_o = (BLANK_CYC != 0) && (dwell_q == BLANK_LAST);

    // The parent registers its outputs from next-state values, so the PWM
    // count and blink phase are handed over one cycle early to line up with
    // the cycle in which those outputs are visible.
    assign pwm_cnt_o  = pwm_d;
    assign blink_on_o = blink_on_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed seven-segment scan controller with blank guard, 16-step
// PWM brightness, per-digit blinking and frame-coherent input latching.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_en           : scan enable (0 forces IDLE on the next edge)
//   i_digit_seg    : digit k segments {a..g} at [7k+6:7k]
//   i_dp           : decimal point per digit
//   i_blink_mask   : 1 = digit blinks
//   i_bright       : brightness 0 (1/16) .. 15 (full)
//   o_seg          : registered segment drive
//   o_seg_dp       : registered decimal point drive
//   o_seg_enb      : registered digit enables, polarity set by ENB_ACTIVE_LOW
//   o_frame_start  : one-cycle pulse on the first cycle of digit 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYC      = 64,
    parameter int BLINK_HZ       = 2,
    parameter bit ENB_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic [7*NUM_DIGITS-1:0] i_digit_seg,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    input  logic [3:0]              i_bright,
    output logic [6:0]              o_seg,
    output logic                    o_seg_dp,
    output logic [NUM_DIGITS-1:0]   o_seg_enb,
    output logic                    o_frame_start
);

    localparam int DWELL      = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] ENB_OFF_ALL = enb_off(ENB_ACTIVE_LOW, NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ENB_OFF     = ENB_OFF_ALL[NUM_DIGITS-1:0];

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic frame_start_d;

    logic [7*NUM_DIGITS-1:0] lat_seg_q, lat_seg_d;
    logic [NUM_DIGITS-1:0]   lat_dp_q, lat_dp_d;
    logic [NUM_DIGITS-1:0]   lat_mask_q, lat_mask_d;
    logic [3:0]              lat_bright_q, lat_bright_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] enb_q, enb_d;
    logic                  fs_q;

    logic       slot_end;
    logic       blank_done;
    logic [3:0] pwm_cnt;
    logic       blink_on;
    logic       tb_restart;

    // Counters are cleared whenever the scan is (or is about to be) idle, so
    // every enable run starts digit 0 with a fresh slot and blink phase on.
    assign tb_restart = (state_q == IDLE) || !i_en;

    seg_scan_timebase #(
        .DWELL      (DWELL),
        .BLANK_CYC  (BLANK_CYC),
        .BLINK_HALF (BLINK_HALF)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (i_en),
        .restart_i    (tb_restart),
        .slot_end_o   (slot_end),
        .blank_done_o (blank_done),
        .pwm_cnt_o    (pwm_cnt),
        .blink_on_o   (blink_on)
    );

    always_comb begin
        state_d       = state_q;
        digit_idx_d   = digit_idx_q;
        frame_start_d = 1'b0;
        if (!i_en) begin
            state_d     = IDLE;
            digit_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_start_d = 1'b1;
                    digit_idx_d   = '0;
                    if (BLANK_CYC == 0) state_d = ON;
                    else                state_d = BLANK;
                end
                BLANK: begin
                    if (blank_done) state_d = ON;
                end
                ON: begin
                    if (slot_end) begin
                        if (BLANK_CYC == 0) state_d = ON;
                        else                state_d = BLANK;
                        if (digit_idx_q == LAST_IDX) begin
                            digit_idx_d   = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            digit_idx_d = digit_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    digit_idx_d = '0;
                end
            endcase
        end
    end

    // Inputs pass into the latches only on a frame start; the output mux uses
    // the _d copies so a frame-start cycle already shows the incoming values.
    always_comb begin
        lat_seg_d    = lat_seg_q;
        lat_dp_d     = lat_dp_q;
        lat_mask_d   = lat_mask_q;
        lat_bright_d = lat_bright_q;
        if (frame_start_d) begin
            lat_seg_d    = i_digit_seg;
            lat_dp_d     = i_dp;
            lat_mask_d   = i_blink_mask;
            lat_bright_d = i_bright;
        end
    end

    always_comb begin
        enb_d = ENB_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (state_d == ON) begin
            seg_d = lat_seg_d[int'(digit_idx_d) * 7 +: 7];
            dp_d  = lat_dp_d[digit_idx_d];
            if ((pwm_cnt <= lat_bright_d) && !(!blink_on && lat_mask_d[digit_idx_d])) begin
                enb_d[digit_idx_d] = ~ENB_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            digit_idx_q  <= '0;
            lat_seg_q    <= '0;
            lat_dp_q     <= '0;
            lat_mask_q   <= '0;
            lat_bright_q <= 4'd0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b0;
            enb_q        <= ENB_OFF;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_idx_q  <= digit_idx_d;
            lat_seg_q    <= lat_seg_d;
            lat_dp_q     <= lat_dp_d;
            lat_mask_q   <= lat_mask_d;
            lat_bright_q <= lat_bright_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            enb_q        <= enb_d;
            fs_q         <= frame_start_d;
        end
    end

    assign o_seg         = seg_q;
    assign o_seg_dp      = dp_q;
    assign o_seg_enb     = enb_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=10, BLANK_CYC=2,
// BLINK_HALF=20, active-low enables. A cycle-level reference model derives
// the expected outputs from the scan rules (slot = k/DWELL, position in
// slot = k%DWELL, blink phase = k/BLINK_HALF parity, PWM = clocks since
// reset mod 16); directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N          = 4;
    localparam int CLK_HZ     = 1000;
    localparam int SCAN_HZ    = 100;
    localparam int BLANK      = 2;
    localparam int BLINK_HZ   = 25;
    localparam int DWELL      = 10;
    localparam int BLINK_HALF = 20;
    localparam int FRAME      = N * DWELL;

    localparam logic [27:0] SEG_A = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] SEG_B = {7'h5E, 7'h39, 7'h7C, 7'h77};
    localparam logic [3:0]  DP_A  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_en = 1'b0;
    logic [27:0] i_digit_seg = '0;
    logic [3:0]  i_dp = '0;
    logic [3:0]  i_blink_mask = '0;
    logic [3:0]  i_bright = '0;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [3:0]  o_seg_enb;
    logic        o_frame_start;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;
    int kNow = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS     (N),
        .CLK_HZ         (CLK_HZ),
        .SCAN_HZ        (SCAN_HZ),
        .BLANK_CYC      (BLANK),
        .BLINK_HZ       (BLINK_HZ),
        .ENB_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_digit_seg   (i_digit_seg),
        .i_dp          (i_dp),
        .i_blink_mask  (i_blink_mask),
        .i_bright      (i_bright),
        .o_seg         (o_seg),
        .o_seg_dp      (o_seg_dp),
        .o_seg_enb     (o_seg_enb),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [27:0] seg, input logic [3:0] dp,
                                 input logic [3:0] mask, input logic [3:0] bright);
        i_en         = en;
        i_digit_seg  = seg;
        i_dp         = dp;
        i_blink_mask = mask;
        i_bright     = bright;
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
        kNow += n;
    endtask

    // Reference model state
    int          pwmCnt = 0;
    int          kCnt = 0;
    int          slot;
    int          pos;
    bit          active = 1'b0;
    bit          blinkOn;
    logic [27:0] snapSeg = '0;
    logic [3:0]  snapDp = '0;
    logic [3:0]  snapMask = '0;
    logic [3:0]  snapBright = '0;
    logic [6:0]  expSeg = '0;
    logic        expDp = 1'b0;
    logic [3:0]  expEnb = 4'hF;
    logic        expFs = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pwmCnt = 0;
                active = 1'b0;
                expSeg = '0;
                expDp  = 1'b0;
                expEnb = 4'hF;
                expFs  = 1'b0;
            end else begin
                pwmCnt = (pwmCnt + 1) % 16;
                expSeg = '0;
                expDp  = 1'b0;
                expEnb = 4'hF;
                expFs  = 1'b0;
                if (!i_en) begin
                    active = 1'b0;
                end else begin
                    if (!active) begin
                        active = 1'b1;
                        kCnt   = 0;
                    end else begin
                        kCnt++;
                    end
                    if ((kCnt % FRAME) == 0) begin
                        snapSeg    = i_digit_seg;
                        snapDp     = i_dp;
                        snapMask   = i_blink_mask;
                        snapBright = i_bright;
                        expFs      = 1'b1;
                    end
                    slot    = (kCnt / DWELL) % N;
                    pos     = kCnt % DWELL;
                    blinkOn = ((kCnt / BLINK_HALF) % 2) == 0;
                    if (pos >= BLANK) begin
                        expSeg = snapSeg[slot*7 +: 7];
                        expDp  = snapDp[slot];
                        if ((pwmCnt <= int'(snapBright)) && !(!blinkOn && snapMask[slot])) begin
                            expEnb[slot] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkOn) begin
                checkOutput("model_enb", 32'(o_seg_enb), 32'(expEnb));
                checkOutput("model_seg", 32'(o_seg), 32'(expSeg));
                checkOutput("model_dp", 32'(o_seg_dp), 32'(expDp));
                checkOutput("model_frame_start", 32'(o_frame_start), 32'(expFs));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int onCnt;
        applyStimulus(1'b0, SEG_A, DP_A, 4'b0000, 4'd15);
        #1 rst_n = 1'b0;
        advance(2);
        checkOn = 1'b1;
        checkOutput("reset_enb", 32'(o_seg_enb), 32'h0000_000F);
        checkOutput("reset_seg", 32'(o_seg), 32'h0);
        checkOutput("reset_fs", 32'(o_frame_start), 32'h0);
        rst_n = 1'b1;
        advance(3);
        checkOutput("idle_enb", 32'(o_seg_enb), 32'hF);

        $display("[TB] scan order at full brightness");
        applyStimulus(1'b1, SEG_A, DP_A, 4'b0000, 4'd15);
        kNow = -1;
        advance(1);
        checkOutput("k0_fs", 32'(o_frame_start), 32'h1);
        checkOutput("k0_enb_blank", 32'(o_seg_enb), 32'hF);
        checkOutput("k0_seg_blank", 32'(o_seg), 32'h0);
        advance(1);
        checkOutput("k1_fs", 32'(o_frame_start), 32'h0);
        checkOutput("k1_enb_blank", 32'(o_seg_enb), 32'hF);
        advance(1);
        checkOutput("d0_enb", 32'(o_seg_enb), 32'hE);
        checkOutput("d0_seg", 32'(o_seg), 32'h3F);
        checkOutput("d0_dp", 32'(o_seg_dp), 32'h1);
        advance(10);
        checkOutput("d1_enb", 32'(o_seg_enb), 32'hD);
        checkOutput("d1_seg", 32'(o_seg), 32'h06);
        checkOutput("d1_dp", 32'(o_seg_dp), 32'h0);
        advance(10);
        checkOutput("d2_enb", 32'(o_seg_enb), 32'hB);
        checkOutput("d2_seg", 32'(o_seg), 32'h5B);
        advance(10);
        checkOutput("d3_enb", 32'(o_seg_enb), 32'h7);
        checkOutput("d3_seg", 32'(o_seg), 32'h4F);
        advance(7);
        checkOutput("k39_fs", 32'(o_frame_start), 32'h0);
        advance(1);
        checkOutput("k40_fs", 32'(o_frame_start), 32'h1);
        checkOutput("k40_enb_blank", 32'(o_seg_enb), 32'hF);

        $display("[TB] frame coherence");
        advance(22);
        checkOutput("coh_d2_old", 32'(o_seg), 32'h5B);
        applyStimulus(1'b1, SEG_B, DP_A, 4'b0000, 4'd15);
        advance(10);
        checkOutput("coh_d3_old", 32'(o_seg), 32'h4F);
        advance(10);
        checkOutput("coh_d0_new", 32'(o_seg), 32'h77);
        checkOutput("coh_d0_enb", 32'(o_seg_enb), 32'hE);

        $display("[TB] pwm brightness 3");
        applyStimulus(1'b1, SEG_B, DP_A, 4'b0000, 4'd3);
        advance(37);
        onCnt = 0;
        repeat (160) begin
            advance(1);
            if (o_seg_enb != 4'hF) onCnt++;
        end
        checkOutput("pwm_on_cycles", 32'(onCnt), 32'd32);

        $display("[TB] blink mask 0110");
        applyStimulus(1'b1, SEG_B, DP_A, 4'b0110, 4'd15);
        advance(3);
        checkOutput("blink_d0_enb", 32'(o_seg_enb), 32'hE);
        advance(10);
        checkOutput("blink_d1_on_phase", 32'(o_seg_enb), 32'hD);
        advance(10);
        checkOutput("blink_d2_suppressed", 32'(o_seg_enb), 32'hF);
        checkOutput("blink_d2_seg", 32'(o_seg), 32'h39);
        advance(10);
        checkOutput("blink_d3_unmasked", 32'(o_seg_enb), 32'h7);

        $display("[TB] enable drop and restart");
        advance(32);
        applyStimulus(1'b0, SEG_B, DP_A, 4'b0110, 4'd15);
        advance(1);
        checkOutput("drop_enb", 32'(o_seg_enb), 32'hF);
        checkOutput("drop_seg", 32'(o_seg), 32'h0);
        checkOutput("drop_fs", 32'(o_frame_start), 32'h0);
        advance(4);
        applyStimulus(1'b1, SEG_A, DP_A, 4'b0000, 4'd15);
        kNow = -1;
        advance(1);
        checkOutput("restart_fs", 32'(o_frame_start), 32'h1);
        checkOutput("restart_enb_blank", 32'(o_seg_enb), 32'hF);
        advance(1);
        checkOutput("restart_fs_once", 32'(o_frame_start), 32'h0);
        advance(1);
        checkOutput("restart_d0_enb", 32'(o_seg_enb), 32'hE);
        checkOutput("restart_d0_seg", 32'(o_seg), 32'h3F);

        $display("[TB] asynchronous reset mid-scan");
        advance(23);
        checkOutput("pre_reset_d2_enb", 32'(o_seg_enb), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_enb", 32'(o_seg_enb), 32'hF);
        checkOutput("async_reset_seg", 32'(o_seg), 32'h0);
        checkOutput("async_reset_fs", 32'(o_frame_start), 32'h0);
        advance(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
